// File: rtl/dice_pkg.sv
// Purpose: shared types and helpers for the dice roller (roll state, die maxima, 7-seg decode).
// Latency: n/a (package only).
// Backpressure: n/a.
package dice_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } roll_state_e;

  // Highest face of each die as 4-digit BCD, indexed by sel:
  // 0=d4 1=d6 2=d8 3=d10 4=d12 5=d20 6=d100.
  function automatic logic [15:0] die_max_bcd(input logic [2:0] sel);
    logic [15:0] m;
    case (sel)
      3'd0:    m = 16'h0004;
      3'd1:    m = 16'h0006;
      3'd2:    m = 16'h0008;
      3'd3:    m = 16'h0010;
      3'd4:    m = 16'h0012;
      3'd5:    m = 16'h0020;
      default: m = 16'h0100;
    endcase
    return m;
  endfunction

  // Active-high segments, a in bit 0 through g in bit 6; non-decimal codes go blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dice_roller_mux_debounce.sv
// Purpose: debounce one raw button; two-flop synchroniser then tick-sampled stability counter.
// Latency: level follows raw after DEBOUNCE_TICKS..DEBOUNCE_TICKS+1 ticks (plus 2 clk sync).
// Backpressure: none.
// Ports: clk, rst_n (async active-low), tick (sample strobe), raw (logical level, 1 = pressed),
//        level (debounced level, 0 after reset).
module dice_debounce #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic [1:0] sync;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= 3'd0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        // Count consecutive samples disagreeing with the current level;
        // any agreeing sample restarts the count.
        if (sync[1] != level) begin
          if (cnt == 3'(DEBOUNCE_TICKS - 1)) begin
            level <= sync[1];
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end else begin
          cnt <= 3'd0;
        end
      end
    end
  end

endmodule

// File: rtl/dice_roller_mux.sv
// Purpose: seven-button dice roller; BCD roll counter shown on NUM_DIGITS multiplexed 7-seg digits.
// Latency: seg/com registered one clk after the scan index; display lights one clk after release.
// Backpressure: none; buttons are free-running inputs, display is free-running output.
// Ports: clk (32768 Hz), rst_n (async active-low), btn[6:0] d4..d100, btn[7] history,
//        btn/seg/com_active_high polarity selects, seg[7:0] (dp in [7], always off), com[NUM_DIGITS-1:0].
// Optional feature macro DICE_HISTORY_EN: holding btn[7] in IDLE shows the previous roll.
module dice_roller_mux
  import dice_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int PRESCALE_W     = 10,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int TIMEOUT_TICKS  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            btn,
  input  logic                  btn_active_high,
  input  logic                  seg_active_high,
  input  logic                  com_active_high,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] com
);

  localparam int RW = 4 * NUM_DIGITS;
  localparam int SW = $clog2(NUM_DIGITS);

  // ---------------- prescaler ----------------
  logic [PRESCALE_W-1:0] presc;
  logic                  tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + PRESCALE_W'(1);
  end

  assign tick = (presc == '0);

  // ---------------- debouncers ----------------
  logic [7:0] btn_log;
  logic [7:0] lvl;
  logic [6:0] die_lvl;
  logic [6:0] die_lvl_q;

  assign btn_log = btn ^ {8{~btn_active_high}};

  for (genvar g = 0; g < 8; g++) begin : g_deb
    dice_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (btn_log[g]),
      .level (lvl[g])
    );
  end

  assign die_lvl = lvl[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) die_lvl_q <= '0;
    else        die_lvl_q <= die_lvl;
  end

  // ---------------- roll FSM ----------------
  roll_state_e   state, state_nxt;
  logic [2:0]    sel, sel_nxt, rise_sel;
  logic [RW-1:0] result, result_nxt, inc_val, max_val, next_roll;
  logic          roll_start, load_timeout, carry;

  always_comb begin
    rise_sel = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (die_lvl[i]) rise_sel = 3'(i);
    end
  end

  // BCD +1 with digit carry; a carry out of the top digit drops, which is how
  // 100 lands as 00 on a two-digit build.
  always_comb begin
    inc_val = result;
    carry   = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (result[4*d +: 4] == 4'd9) begin
          inc_val[4*d +: 4] = 4'd0;
        end else begin
          inc_val[4*d +: 4] = result[4*d +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Truncating the maximum to the display width makes a two-digit d100 wrap at 00.
  assign max_val   = RW'(die_max_bcd(sel));
  assign next_roll = (result == max_val) ? RW'(1) : inc_val;

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    result_nxt   = result;
    roll_start   = 1'b0;
    load_timeout = 1'b0;
    case (state)
      IDLE: begin
        // Previous cycle all released and now something up: a fresh press.
        // Holding any die button across a roll therefore blocks re-arming.
        if (die_lvl_q == 7'd0 && die_lvl != 7'd0) begin
          state_nxt  = ROLL;
          sel_nxt    = rise_sel;
          result_nxt = RW'(1);
          roll_start = 1'b1;
        end
      end
      ROLL: begin
        if (die_lvl[sel]) begin
          result_nxt = next_roll;
        end else begin
          state_nxt    = IDLE;
          load_timeout = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 3'd0;
      result <= RW'(1);
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      result <= result_nxt;
    end
  end

  // ---------------- optional history ----------------
  logic          show_prev;
  logic [RW-1:0] disp_val;

`ifdef DICE_HISTORY_EN
  logic [RW-1:0] prev_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          prev_result <= RW'(1);
    else if (roll_start) prev_result <= result;
  end

  assign show_prev = (state == IDLE) && lvl[7];
  assign disp_val  = show_prev ? prev_result : result;
`else
  logic unused_hist;
  assign unused_hist = lvl[7] ^ roll_start;
  assign show_prev   = 1'b0;
  assign disp_val    = result;
`endif

  // ---------------- display timeout ----------------
  logic [7:0] timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 8'd0;
    end else if (load_timeout || show_prev) begin
      timeout <= 8'(TIMEOUT_TICKS);
    end else if (tick && timeout != 8'd0) begin
      timeout <= timeout - 8'd1;
    end
  end

  // ---------------- scan and drive ----------------
  logic [SW-1:0]         scan_idx;
  logic [NUM_DIGITS-1:0] blank;
  logic                  nz_above;
  logic                  lit;
  logic [3:0]            cur_digit;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] com_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               scan_idx <= '0;
    else if (scan_idx == SW'(NUM_DIGITS - 1)) scan_idx <= '0;
    else                                      scan_idx <= scan_idx + SW'(1);
  end

  always_comb begin
    nz_above = 1'b0;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      nz_above = nz_above | (disp_val[4*i +: 4] != 4'd0);
      blank[i] = ~nz_above;
    end
    // The only all-zero value is the two-digit percentile 00, shown in full.
    if (disp_val == '0) blank = '0;
  end

  assign cur_digit = disp_val[4*int'(scan_idx) +: 4];
  assign lit       = (state == IDLE) && (timeout != 8'd0) && !blank[scan_idx];

  // Registered in logical (active-high) form so reset is a constant;
  // pad polarity is applied after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 8'h00;
      com_q <= '0;
    end else if (lit) begin
      seg_q <= {1'b0, bcd_to_seg(cur_digit)};
      com_q <= NUM_DIGITS'(1) << scan_idx;
    end else begin
      seg_q <= 8'h00;
      com_q <= '0;
    end
  end

  assign seg = seg_q ^ {8{~seg_active_high}};
  assign com = com_q ^ {NUM_DIGITS{~com_active_high}};

endmodule

// File: tb/tb_dice_roller_mux.sv
// Purpose: directed self-checking bench for dice_roller_mux (3-digit and 2-digit builds side by side).
// Latency: n/a.
// Backpressure: n/a.
module tb_dice_roller_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn = 8'h00;
  logic       btn_active_high = 1'b1;
  logic       seg_active_high = 1'b1;
  logic       com_active_high = 1'b1;
  logic [7:0] seg3, seg2;
  logic [2:0] com3;
  logic [1:0] com2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] shown3 [3];
  logic [7:0] shown2 [2];
  int         lit3, lit2;
  bit         onehot_ok, dark_ok;

  always #5 clk = ~clk;

  dice_roller_mux #(.NUM_DIGITS(3), .PRESCALE_W(1), .DEBOUNCE_TICKS(2), .TIMEOUT_TICKS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_active_high(btn_active_high),
    .seg_active_high(seg_active_high), .com_active_high(com_active_high),
    .seg(seg3), .com(com3)
  );

  dice_roller_mux #(.NUM_DIGITS(2), .PRESCALE_W(1), .DEBOUNCE_TICKS(2), .TIMEOUT_TICKS(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_active_high(btn_active_high),
    .seg_active_high(seg_active_high), .com_active_high(com_active_high),
    .seg(seg2), .com(com2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raw press of one die button for k clk; both edges share a clk phase so
  // the debounced high time equals k.
  task automatic press(input int idx, input int k);
    @(posedge clk); #1 btn[idx] = 1'b1;
    repeat (k) @(posedge clk);
    #1 btn[idx] = 1'b0;
  endtask

  // Observe both displays for n clk, recording each digit's segments.
  task automatic watch(input int n);
    for (int i = 0; i < 3; i++) shown3[i] = 8'h00;
    for (int i = 0; i < 2; i++) shown2[i] = 8'h00;
    lit3 = 0; lit2 = 0; onehot_ok = 1'b1; dark_ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (com3 != 3'b000) lit3++;
      if (com2 != 2'b00)  lit2++;
      for (int i = 0; i < 3; i++) if (com3[i]) shown3[i] = seg3;
      for (int i = 0; i < 2; i++) if (com2[i]) shown2[i] = seg2;
      if (!$onehot0(com3) || !$onehot0(com2)) onehot_ok = 1'b0;
      if ((com3 == 3'b000 && seg3 != 8'h00) || (com2 == 2'b00 && seg2 != 8'h00)) dark_ok = 1'b0;
    end
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_seg3", seg3, 8'h00);
    check("reset_com3", com3, 3'b000);
    check("reset_seg2", seg2, 8'h00);
    check("reset_com2", com2, 2'b00);
    watch(20);
    check("idle_dark", lit3, 0);

    // ---- d6, K=14 -> 2 ----
    press(1, 14);
    watch(40);
    check("d6_dig0", shown3[0], 8'h5B);
    check("d6_dig1_blank", shown3[1], 8'h00);
    check("d6_dig2_blank", shown3[2], 8'h00);
    check("d6_2dig_dig0", shown2[0], 8'h5B);
    check("d6_2dig_dig1_blank", shown2[1], 8'h00);
    check("d6_onehot", onehot_ok, 1'b1);
    check("d6_seg_dark", dark_ok, 1'b1);

    // ---- d100, K=100 -> "100" / "00"; also timeout length ----
    press(6, 100);
    watch(40);
    check("d100_dig0", shown3[0], 8'h3F);
    check("d100_dig1", shown3[1], 8'h3F);
    check("d100_dig2", shown3[2], 8'h06);
    check("d100_2dig_dig0", shown2[0], 8'h3F);
    check("d100_2dig_dig1", shown2[1], 8'h3F);
    check("timeout_len", (lit3 >= 4 && lit3 <= 8), 1'b1);
    check("timeout_dark", com3, 3'b000);

    // ---- d4 + d20 together: d4 wins, wraps at 4 (K=10 -> 2) ----
    @(posedge clk); #1 btn[0] = 1'b1; btn[5] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn[0] = 1'b0;
    watch(40);
    check("d4d20_dig0", shown3[0], 8'h5B);
    check("d4d20_dig1_blank", shown3[1], 8'h00);
    press(0, 6);
    watch(40);
    check("no_roll_while_held", lit3, 0);
    @(posedge clk); #1 btn[5] = 1'b0;
    repeat (12) @(posedge clk);
    press(0, 4);
    watch(40);
    check("d4_after_release", shown3[0], 8'h66);

    // ---- d6 K=8 -> 2, then history button ----
    press(1, 8);
    watch(40);
    check("d6_k8_dig0", shown3[0], 8'h5B);
    @(posedge clk); #1 btn[7] = 1'b1;
    repeat (12) @(posedge clk);
    watch(20);
`ifdef DICE_HISTORY_EN
    check("history_dig0", shown3[0], 8'h66);
    check("history_held_lit", (lit3 > 0), 1'b1);
`else
    check("history_ignored", lit3, 0);
`endif
    @(posedge clk); #1 btn[7] = 1'b0;
    watch(40);

    // ---- 1-tick glitch on d6 ----
    @(posedge clk); #1 btn[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn[1] = 1'b0;
    watch(40);
    check("glitch_no_roll", lit3, 0);

    // ---- reset mid-roll ----
    @(posedge clk); #1 btn[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0; btn[2] = 1'b0;
    @(negedge clk);
    check("midreset_com3", com3, 3'b000);
    check("midreset_seg3", seg3, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    watch(40);
    check("midreset_no_freeze", lit3, 0);

    // ---- output polarity while dark ----
    #1 seg_active_high = 1'b0; com_active_high = 1'b0;
    #1;
    check("pol_seg3", seg3, 8'hFF);
    check("pol_com3", com3, 3'b111);
    check("pol_com2", com2, 2'b11);
    seg_active_high = 1'b1; com_active_high = 1'b1;

    // ---- post-reset roll starts from 1 (d8, K=4 -> 4) ----
    press(2, 4);
    watch(40);
    check("post_reset_d8", shown3[0], 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
